spi_cfg_writer: RTL

SPI controller that configures the chip's SPI register-file peripheral. It accepts register-write requests (7-bit address, 8-bit data) on a valid/ready port and queues them in a small FIFO. Each request is serialised as one 16-bit mode-0 write frame on ncs/sclk/copi. The block sits on the host/test side of the SPI link and is the only driver of those three lines.

---
 rtl/spi_cfg_writer_if.sv | 28 ++
 rtl/spi_cfg_writer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_writer_if.sv
// Request channel of the SPI configuration writer.
// A host pushes register writes (7-bit address, 8-bit data) with a
// valid/ready handshake; a transfer happens on every clock edge where
// req_valid and req_ready are both high.
//   req_valid  host -> writer  request present
//   req_ready  writer -> host  queue has room
//   req_addr   host -> writer  target register address
//   req_data   host -> writer  value to write
interface spi_cfg_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/spi_cfg_writer.sv
// SPI configuration writer.
// Queues register-write requests in a small FIFO and sends each one as a
// 16-bit mode-0 write frame, LSB first: bit0 = 1 (write flag),
// bits[7:1] = address, bits[15:8] = data. Sole driver of ncs/sclk/copi.
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   req   request channel (slave side of spi_cfg_writer_if)
//   busy  FSM not idle or queue not empty
//   done  one-cycle pulse in the cycle ncs returns high after a frame
//   ncs   chip select, active low, registered
//   sclk  serial clock, idle low, registered
//   copi  serial data, registered, changes only while sclk is low
module spi_cfg_writer #(
  parameter int CLK_DIV    = 4,  // clk cycles per sclk half-period, 2..255
  parameter int CS_SETUP   = 2,  // ncs low / sclk low before first rise, >= 1
  parameter int CS_HOLD    = 2,  // sclk low after last fall before ncs rises, >= 1
  parameter int CS_GAP     = 4,  // ncs high cycles between frames, >= 1
  parameter int FIFO_DEPTH = 4   // power of two, 2..16
) (
  input  logic            clk,
  input  logic            rst,
  spi_cfg_writer_if.slave req,
  output logic            busy,
  output logic            done,
  output logic            ncs,
  output logic            sclk,
  output logic            copi
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // One phase counter serves SETUP, HOLD and GAP, sized for the longest.
  localparam int PH_MAX = (CS_SETUP > CS_HOLD)
                        ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                        : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int PW = $clog2(PH_MAX + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // ---------------------------------------------------------------- queue
  logic [14:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [14:0]   head;

  logic [2:0]    state_q, state_d;

  assign full          = (count_q == CW'(FIFO_DEPTH));
  assign empty         = (count_q == '0);
  // Held low during reset so nothing is accepted while the block clears.
  assign req.req_ready = !full && !rst;
  assign push          = req.req_valid && req.req_ready;
  // The FSM pops only from IDLE; a full queue does not pass requests through.
  assign pop           = (state_q == ST_IDLE) && !empty;
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req.req_data, req.req_addr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ------------------------------------------------------------------ FSM
  logic [15:0]   shreg_q, shreg_d;
  logic [4:0]    bit_q, bit_d;
  logic [7:0]    div_q, div_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          ncs_q, ncs_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    ph_d    = ph_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        copi_d = 1'b0;
        if (!empty) begin
          shreg_d = {head, 1'b1};
          ncs_d   = 1'b0;
          copi_d  = 1'b1;   // bit0 is always the write flag
          ph_d    = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (ph_q == PW'(CS_SETUP - 1)) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (div_q == 8'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance copi here so it is settled a full
            // half-period before the next rising edge.
            sclk_d = 1'b0;
            if (bit_q == 5'd15) begin
              bit_d   = 5'd16;
              ph_d    = '0;
              state_d = ST_HOLD;   // copi keeps bit15 through HOLD
            end else begin
              bit_d   = bit_q + 5'd1;
              shreg_d = shreg_q >> 1;
              copi_d  = shreg_q[1];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_HOLD: begin
        if (ph_q == PW'(CS_HOLD - 1)) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          ph_d    = '0;
          state_d = ST_GAP;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (ph_q == PW'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      default: begin
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      ph_q    <= '0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE) || !empty;
  assign done = done_q;
  assign ncs  = ncs_q;
  assign sclk = sclk_q;
  assign copi = copi_q;

endmodule
